// File: rtl/function_sweep_checker_if.sv
// Bundles the checker's stimulus, response and result signals.
// The checker owns the master modport; the lab environment owns the slave modport.
interface function_sweep_checker_if #(
    parameter int N_IN  = 3,
    parameter int OUT_W = 1
);
    // start is a single-cycle request sampled on the rising clock edge.
    // It is accepted in IDLE or DONE and ignored while busy.
    // There is no ready signal: busy and done tell the requester whether a start will be taken.
    logic                          start;
    logic [OUT_W*(2**N_IN)-1:0]    truth_table;
    logic [N_IN-1:0]               dut_in;
    logic [OUT_W-1:0]              dut_out;
    logic                          busy;
    logic                          done;
    logic                          pass;
    logic [N_IN:0]                 err_count;
    logic [N_IN-1:0]               first_err;
    logic                          first_err_v;

    modport master (
        input  start, truth_table, dut_out,
        output dut_in, busy, done, pass, err_count, first_err, first_err_v
    );

    modport slave (
        output start, truth_table, dut_out,
        input  dut_in, busy, done, pass, err_count, first_err, first_err_v
    );
endinterface

// File: rtl/function_sweep_checker.sv
// Exhaustive sweep of a combinational function under test. The sweep uses binary or Gray order.
// Each vector is held for DWELL clocks and checked against a truth table captured when the sweep starts.
module function_sweep_checker #(
    parameter int N_IN  = 3,
    parameter int OUT_W = 1,
    parameter int DWELL = 20,
    parameter int GRAY  = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    function_sweep_checker_if.master   bus,
    output logic [1:0]                 o_dbg_state
);
    localparam int NV  = 1 << N_IN;
    localparam int TW  = OUT_W * NV;
    localparam int TSW = (TW > 1) ? $clog2(TW) : 1;
    localparam int DW  = $clog2(DWELL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state,       w_state;
    logic [TW-1:0]   r_table,       w_table;
    logic [N_IN-1:0] r_idx,         w_idx;
    logic [DW-1:0]   r_dwell,       w_dwell;
    logic [N_IN-1:0] r_dut_in,      w_dut_in;
    logic            r_busy,        w_busy;
    logic            r_done,        w_done;
    logic            r_pass,        w_pass;
    logic [N_IN:0]   r_err,         w_err;
    logic [N_IN-1:0] r_first_err,   w_first_err;
    logic            r_first_err_v, w_first_err_v;

    logic [TSW-1:0]   w_sel;
    logic [OUT_W-1:0] w_expected;
    logic             w_mismatch;
    logic             w_last_dwell;
    logic             w_last_vec;
    logic [N_IN-1:0]  w_idx_inc;

    function automatic logic [N_IN-1:0] f_map(input logic [N_IN-1:0] v);
        if (GRAY != 0) return v ^ (v >> 1);
        else           return v;
    endfunction

    // The expected value is indexed by the vector actually applied, not by idx.
    assign w_sel        = TSW'(int'(r_dut_in) * OUT_W);
    assign w_expected   = r_table[w_sel +: OUT_W];
    assign w_mismatch   = (bus.dut_out != w_expected);
    assign w_last_dwell = (r_dwell == DW'(DWELL - 1));
    assign w_last_vec   = (r_idx == {N_IN{1'b1}});
    assign w_idx_inc    = r_idx + N_IN'(1);

    always_comb begin
        w_state       = r_state;
        w_table       = r_table;
        w_idx         = r_idx;
        w_dwell       = r_dwell;
        w_dut_in      = r_dut_in;
        w_busy        = r_busy;
        w_done        = r_done;
        w_pass        = r_pass;
        w_err         = r_err;
        w_first_err   = r_first_err;
        w_first_err_v = r_first_err_v;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state       = S_RUN;
                    w_table       = bus.truth_table;
                    w_idx         = '0;
                    w_dwell       = '0;
                    w_dut_in      = f_map('0);
                    w_busy        = 1'b1;
                    w_done        = 1'b0;
                    w_pass        = 1'b0;
                    w_err         = '0;
                    w_first_err   = '0;
                    w_first_err_v = 1'b0;
                end
            end
            S_RUN: begin
                if (w_last_dwell) begin
                    if (w_mismatch) begin
                        w_err = r_err + (N_IN+1)'(1);
                        if (!r_first_err_v) begin
                            w_first_err   = r_dut_in;
                            w_first_err_v = 1'b1;
                        end
                    end
                    // The final vector stays applied after the sweep ends.
                    if (w_last_vec) begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_err == '0);
                    end else begin
                        w_idx    = w_idx_inc;
                        w_dwell  = '0;
                        w_dut_in = f_map(w_idx_inc);
                    end
                end else begin
                    w_dwell = r_dwell + DW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_table       <= '0;
            r_idx         <= '0;
            r_dwell       <= '0;
            r_dut_in      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err         <= '0;
            r_first_err   <= '0;
            r_first_err_v <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_table       <= w_table;
            r_idx         <= w_idx;
            r_dwell       <= w_dwell;
            r_dut_in      <= w_dut_in;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_pass        <= w_pass;
            r_err         <= w_err;
            r_first_err   <= w_first_err;
            r_first_err_v <= w_first_err_v;
        end
    end

    assign bus.dut_in      = r_dut_in;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.err_count   = r_err;
    assign bus.first_err   = r_first_err;
    assign bus.first_err_v = r_first_err_v;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_function_sweep_checker.sv
// Drives three checker configurations with lab functions built from truth tables.
// Each sweep is compared with a model that lists the vectors and finds the mismatches.
module tb_function_sweep_checker;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int cfg_n [3] = '{3, 3, 4};
    int cfg_w [3] = '{1, 1, 2};
    int cfg_d [3] = '{4, 4, 2};
    int cfg_g [3] = '{0, 1, 1};

    logic        start_r [3];
    logic [31:0] tt_r    [3];
    logic [31:0] lab_r   [3];

    logic [3:0] exp_q[$];

    function automatic logic [1:0] field(input logic [31:0] t, input int v, input int w);
        logic [31:0] s;
        s = t >> (v * w);
        return (w == 1) ? {1'b0, s[0]} : s[1:0];
    endfunction

    function_sweep_checker_if #(.N_IN(3), .OUT_W(1)) if0 ();
    function_sweep_checker_if #(.N_IN(3), .OUT_W(1)) if1 ();
    function_sweep_checker_if #(.N_IN(4), .OUT_W(2)) if2 ();

    logic [1:0] dbg0, dbg1, dbg2;
    logic [1:0] lf0, lf1, lf2;

    assign if0.start       = start_r[0];
    assign if1.start       = start_r[1];
    assign if2.start       = start_r[2];
    assign if0.truth_table = tt_r[0][7:0];
    assign if1.truth_table = tt_r[1][7:0];
    assign if2.truth_table = tt_r[2];
    assign lf0 = field(lab_r[0], int'(if0.dut_in), 1);
    assign lf1 = field(lab_r[1], int'(if1.dut_in), 1);
    assign lf2 = field(lab_r[2], int'(if2.dut_in), 2);
    assign if0.dut_out = lf0[0];
    assign if1.dut_out = lf1[0];
    assign if2.dut_out = lf2;

    function_sweep_checker #(.N_IN(3), .OUT_W(1), .DWELL(4), .GRAY(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .bus(if0), .o_dbg_state(dbg0));
    function_sweep_checker #(.N_IN(3), .OUT_W(1), .DWELL(4), .GRAY(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .bus(if1), .o_dbg_state(dbg1));
    function_sweep_checker #(.N_IN(4), .OUT_W(2), .DWELL(2), .GRAY(1)) u_dut2 (
        .clk(clk), .resetn(resetn), .bus(if2), .o_dbg_state(dbg2));

    logic [3:0] ob_in   [3];
    logic [4:0] ob_err  [3];
    logic [3:0] ob_fe   [3];
    logic       ob_busy [3];
    logic       ob_done [3];
    logic       ob_pass [3];
    logic       ob_fv   [3];

    assign ob_in[0]   = {1'b0, if0.dut_in};
    assign ob_in[1]   = {1'b0, if1.dut_in};
    assign ob_in[2]   = if2.dut_in;
    assign ob_err[0]  = {1'b0, if0.err_count};
    assign ob_err[1]  = {1'b0, if1.err_count};
    assign ob_err[2]  = if2.err_count;
    assign ob_fe[0]   = {1'b0, if0.first_err};
    assign ob_fe[1]   = {1'b0, if1.first_err};
    assign ob_fe[2]   = if2.first_err;
    assign ob_busy[0] = if0.busy;
    assign ob_busy[1] = if1.busy;
    assign ob_busy[2] = if2.busy;
    assign ob_done[0] = if0.done;
    assign ob_done[1] = if1.done;
    assign ob_done[2] = if2.done;
    assign ob_pass[0] = if0.pass;
    assign ob_pass[1] = if1.pass;
    assign ob_pass[2] = if2.pass;
    assign ob_fv[0]   = if0.first_err_v;
    assign ob_fv[1]   = if1.first_err_v;
    assign ob_fv[2]   = if2.first_err_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cleared(input int k, input string tag);
        check($sformatf("%s_dut_in%0d", tag, k), ob_in[k],   0);
        check($sformatf("%s_busy%0d",   tag, k), ob_busy[k], 0);
        check($sformatf("%s_done%0d",   tag, k), ob_done[k], 0);
        check($sformatf("%s_pass%0d",   tag, k), ob_pass[k], 0);
        check($sformatf("%s_err%0d",    tag, k), ob_err[k],  0);
        check($sformatf("%s_fe%0d",     tag, k), ob_fe[k],   0);
        check($sformatf("%s_fv%0d",     tag, k), ob_fv[k],   0);
    endtask

    // Runs one sweep on instance k and compares everything with the model built from tt and lab.
    task automatic run_sweep(input int k, input logic [31:0] tt, input logic [31:0] lab, input bit disturb);
        int n, w, d, nv, e_err, e_first, busy_cnt, limit;
        bit e_fv;
        logic [3:0] v, last_v, want;
        n = cfg_n[k]; w = cfg_w[k]; d = cfg_d[k]; nv = 1 << n;
        exp_q.delete();
        e_err = 0; e_first = 0; e_fv = 1'b0; last_v = '0;
        for (int i = 0; i < nv; i++) begin
            v = 4'((cfg_g[k] != 0) ? (i ^ (i >> 1)) : i);
            for (int c = 0; c < d; c++) exp_q.push_back(v);
            if (field(tt, int'(v), w) != field(lab, int'(v), w)) begin
                if (!e_fv) begin
                    e_first = int'(v);
                    e_fv = 1'b1;
                end
                e_err++;
            end
            last_v = v;
        end

        @(negedge clk);
        tt_r[k] = tt; lab_r[k] = lab; start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
        check("acc_done", ob_done[k], 0);
        check("acc_pass", ob_pass[k], 0);
        check("acc_err",  ob_err[k],  0);
        check("acc_fv",   ob_fv[k],   0);

        busy_cnt = 0;
        limit = 2 * d * nv + 8;
        while (ob_busy[k] && busy_cnt < limit) begin
            busy_cnt++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("dut_in_seq", ob_in[k], want);
            end
            if (disturb && busy_cnt == 3) start_r[k] = 1'b1;
            if (disturb && busy_cnt == 4) start_r[k] = 1'b0;
            if (disturb && busy_cnt == 6) tt_r[k] = ~tt;
            @(negedge clk);
        end
        check("busy_len",  busy_cnt,     d * nv);
        check("q_left",    exp_q.size(), 0);
        check("done",      ob_done[k],   1);
        check("busy_end",  ob_busy[k],   0);
        check("pass",      ob_pass[k],   (e_err == 0) ? 1 : 0);
        check("err_count", ob_err[k],    e_err);
        check("first_v",   ob_fv[k],     e_fv);
        if (e_fv) check("first_err", ob_fe[k], e_first);
        check("hold_last", ob_in[k],     last_v);
    endtask

    initial begin
        int k, bits;
        logic [31:0] t, m;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0; tt_r[i] = '0; lab_r[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_cleared(i, "rst");
        resetn = 1'b1;

        // Majority function: a matching lab function, then a lab output stuck at 0.
        run_sweep(0, 32'hE8, 32'hE8, 1'b0);
        run_sweep(0, 32'hE8, 32'h00, 1'b0);

        // 3-input XOR in Gray order: XOR matches the table, XNOR mismatches every vector.
        run_sweep(1, 32'h96, 32'h96, 1'b0);
        run_sweep(1, 32'h96, 32'h69, 1'b0);

        // Reset asserted partway through a sweep.
        @(negedge clk);
        start_r[0] = 1'b1; tt_r[0] = 32'hE8; lab_r[0] = 32'h00;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_rst_in", ob_in[0], 3);
        #2 resetn = 1'b0;
        #1 check_cleared(0, "async_rst");
        @(negedge clk);
        resetn = 1'b1;
        run_sweep(0, 32'hE8, 32'hE8, 1'b0);

        // Start pulses and table changes while the sweep is running.
        run_sweep(0, 32'hE8, 32'hE8, 1'b1);
        run_sweep(1, 32'h96, 32'h96, 1'b1);

        // Wide configuration: a matching lab function, then a re-run started from DONE with errors.
        t = $urandom();
        run_sweep(2, t, t, 1'b0);
        run_sweep(2, t, t ^ 32'h0030_0000, 1'b0);

        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(0, 2);
            bits = cfg_w[k] << cfg_n[k];
            t = $urandom();
            m = '0;
            repeat ($urandom_range(0, 3)) m = m | (32'h1 << $urandom_range(0, bits - 1));
            run_sweep(k, t, t ^ m, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
